// File: rtl/regwr_pkg.sv
// Shared constants for the register-file write arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package regwr_pkg;

  // Default build configuration
  localparam int NUM_REQ_DEF = 3;
  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 4;

  // Requester IDs as wired at the top level
  localparam int REQ_SALU = 0;
  localparam int REQ_VALU = 1;
  localparam int REQ_MEM  = 2;

  // Width of a requester index; never narrower than one bit
  function automatic int calc_src_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first valid index at or after i_ptr (mod N).
// Latency: zero (pure combinational).
// Backpressure: i_en=0 forces an empty grant.
// Ports: i_valid  request vector
//        i_ptr    highest-priority index this cycle
//        i_en     pick enable
//        o_grant  one-hot grant (or zero)
//        o_idx    encoded grant index (0 when no grant)
//        o_any    a grant was issued
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_valid,
  input  logic [IDX_W-1:0] i_ptr,
  input  logic             i_en,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int   w_k;
  logic w_found;

  // Walk outward from the pointer; the first valid hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_k     = 0;
    for (int off = 0; off < N; off++) begin
      w_k = (int'(i_ptr) + off) % N;
      if (i_en && !w_found && i_valid[w_k]) begin
        o_grant[w_k] = 1'b1;
        o_idx        = IDX_W'(w_k);
        w_found      = 1'b1;
      end
    end
  end

  assign o_any = w_found;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port between NUM_REQ producers.
// Latency: one cycle from accepted request to the registered wr_en strobe; one write per cycle sustained.
// Backpressure: stall (or reset) drops every req_ready combinationally; requesters hold until accepted.
// Ports: clk/reset (async, active-high); stall; req_valid/req_ready/req_addr/req_data (packed per requester);
//        wr_en/wr_addr/wr_data/wr_src registered write port; contention = >=2 valid last unstalled cycle.
// Option: define REGWR_ZERO_GUARD_EN to suppress the write strobe for address 0 (handshake still completes).
module regfile_wr_arbiter
  import regwr_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  parameter  int ADDR_W  = ADDR_W_DEF,
  localparam int SRC_W   = calc_src_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [SRC_W-1:0]          wr_src,
  output logic                      contention
);

  logic [SRC_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] w_grant;
  logic [SRC_W-1:0]   w_idx;
  logic               w_any;
  logic               w_pick_en;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  logic [SRC_W-1:0]   w_ptr_nxt;
  logic               w_wr_go;
  logic               w_multi;

  // Ready must be low while reset is held, even though the pointer is already cleared.
  assign w_pick_en = ~stall & ~reset;

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (SRC_W)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_pick_en),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign req_ready  = w_grant;
  assign w_sel_addr = req_addr[int'(w_idx)*ADDR_W +: ADDR_W];
  assign w_sel_data = req_data[int'(w_idx)*DATA_W +: DATA_W];
  // Explicit modulo so non-power-of-two requester counts wrap to 0.
  assign w_ptr_nxt  = SRC_W'((int'(w_idx) + 1) % NUM_REQ);
  assign w_multi    = ($countones(req_valid) >= 2);

`ifdef REGWR_ZERO_GUARD_EN
  // Register 0 is hardwired to zero: accept the request but never strobe it.
  assign w_wr_go = w_any & (w_sel_addr != '0);
`else
  assign w_wr_go = w_any;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      wr_src     <= '0;
      contention <= 1'b0;
    end else begin
      if (w_any) begin
        r_ptr <= w_ptr_nxt;
      end
      wr_en <= w_wr_go;
      if (w_wr_go) begin
        wr_addr <= w_sel_addr;
        wr_data <= w_sel_data;
        wr_src  <= w_idx;
      end
      contention <= ~stall & w_multi;
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
module tb_regfile_wr_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [SW-1:0]   wr_src;
  logic            contention;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_src     (wr_src),
    .contention (contention)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    stall     = 1'b0;
    req_valid = '0;
    tick();
    reset = 1'b0;
    #1;
  endtask

  typedef struct {
    logic [N-1:0]  v;
    logic          s;
    logic [N-1:0]  rdy;
    logic          en;
    logic [SW-1:0] src;
    logic          cont;
  } vec_t;

  vec_t tbl [11];

  // Reference model state
  int          m_ptr;
  logic        m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [SW-1:0] m_src;
  logic        m_cont;
  logic        pend  [N];
  logic [AW-1:0] p_addr [N];
  logic [DW-1:0] p_data [N];
  int          wait_c [N];

  initial begin
    // Arbitration sequence starting from a fresh reset (pointer 0).
    // Requester i always presents addr i+1, data 0xA0+i.
    tbl[0]  = '{v:3'b111, s:0, rdy:3'b001, en:1, src:0, cont:1};
    tbl[1]  = '{v:3'b111, s:0, rdy:3'b010, en:1, src:1, cont:1};
    tbl[2]  = '{v:3'b111, s:0, rdy:3'b100, en:1, src:2, cont:1};
    tbl[3]  = '{v:3'b011, s:0, rdy:3'b001, en:1, src:0, cont:1};
    tbl[4]  = '{v:3'b010, s:0, rdy:3'b010, en:1, src:1, cont:0};
    tbl[5]  = '{v:3'b100, s:1, rdy:3'b000, en:0, src:1, cont:0};
    tbl[6]  = '{v:3'b100, s:1, rdy:3'b000, en:0, src:1, cont:0};
    tbl[7]  = '{v:3'b100, s:0, rdy:3'b100, en:1, src:2, cont:0};
    tbl[8]  = '{v:3'b000, s:0, rdy:3'b000, en:0, src:2, cont:0};
    tbl[9]  = '{v:3'b101, s:0, rdy:3'b001, en:1, src:0, cont:1};
    tbl[10] = '{v:3'b100, s:0, rdy:3'b100, en:1, src:2, cont:0};

    req_addr = '0;
    req_data = '0;

    // ---- Reset values with every request valid ----
    reset = 1'b1; stall = 1'b0; req_valid = 3'b111;
    #1;
    chk("rst_ready", req_ready, 3'b000);
    tick();
    chk("rst_ready_edge", req_ready, 3'b000);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_src", wr_src, 0);
    chk("rst_contention", contention, 0);
    reset = 1'b0;
    #1;
    chk("first_grant", req_ready, 3'b001);
    req_valid = '0;
    tick();

    // ---- Single requester 1 ----
    set_req(1, 4'd5, 32'hDEADBEEF);
    req_valid = 3'b010;
    #1;
    chk("single_ready", req_ready, 3'b010);
    tick();
    req_valid = '0;
    chk("single_wr_en", wr_en, 1);
    chk("single_wr_addr", wr_addr, 5);
    chk("single_wr_data", wr_data, 32'hDEADBEEF);
    chk("single_wr_src", wr_src, 1);
    tick();
    chk("single_wr_en_drop", wr_en, 0);
    req_valid = 3'b111;
    #1;
    chk("single_ptr2", req_ready, 3'b100);
    req_valid = '0;

    // ---- Table-driven arbitration ----
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), DW'(32'hA0 + i));
    for (int t = 0; t < 11; t++) begin
      req_valid = tbl[t].v;
      stall     = tbl[t].s;
      #1;
      chk($sformatf("tbl%0d_ready", t), req_ready, tbl[t].rdy);
      tick();
      chk($sformatf("tbl%0d_wr_en", t), wr_en, tbl[t].en);
      chk($sformatf("tbl%0d_wr_src", t), wr_src, tbl[t].src);
      chk($sformatf("tbl%0d_wr_addr", t), wr_addr, tbl[t].src + 1);
      chk($sformatf("tbl%0d_wr_data", t), wr_data, 32'hA0 + tbl[t].src);
      chk($sformatf("tbl%0d_contention", t), contention, tbl[t].cont);
    end
    req_valid = '0; stall = 1'b0;

    // ---- Reset between ready and the edge: no write ever appears ----
    do_reset();
    set_req(0, 4'd7, 32'h0BAD0BAD);
    req_valid = 3'b001;
    #1;
    chk("rstmid_ready", req_ready, 3'b001);
    reset = 1'b1;
    #1;
    chk("rstmid_ready_rst", req_ready, 3'b000);
    tick();
    chk("rstmid_wr_en", wr_en, 0);
    chk("rstmid_wr_data", wr_data, 0);
    req_valid = '0;
    reset = 1'b0;
    tick();
    chk("rstmid_wr_en2", wr_en, 0);
    // Transfer, then reset while the strobe is high
    req_valid = 3'b001;
    tick();
    req_valid = '0;
    chk("rststrobe_wr_en", wr_en, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rststrobe_async_drop", wr_en, 0);
    tick();
    reset = 1'b0;
    req_valid = 3'b111;
    #1;
    chk("rststrobe_ptr0", req_ready, 3'b001);
    req_valid = '0;
    tick();

    // ---- Address 0 write ----
    do_reset();
    set_req(0, 4'd0, 32'h1234);
    req_valid = 3'b001;
    #1;
    chk("zero_ready", req_ready, 3'b001);
    tick();
    req_valid = '0;
`ifdef REGWR_ZERO_GUARD_EN
    chk("zero_wr_en", wr_en, 0);
    chk("zero_wr_data", wr_data, 0);
`else
    chk("zero_wr_en", wr_en, 1);
    chk("zero_wr_addr", wr_addr, 0);
    chk("zero_wr_data", wr_data, 32'h1234);
`endif
    req_valid = 3'b011;
    #1;
    chk("zero_ptr1", req_ready, 3'b010);
    req_valid = '0;

    // ---- Randomized traffic against the reference model ----
    do_reset();
    m_ptr = 0; m_en = 0; m_addr = '0; m_data = '0; m_src = '0; m_cont = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; wait_c[i] = 0; p_addr[i] = '0; p_data[i] = '0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      int best, bestd, nv;
      logic [N-1:0] exp_rdy;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]   = 1;
          p_addr[i] = AW'($urandom);
          p_data[i] = $urandom;
          wait_c[i] = 0;
        end
        req_valid[i] = pend[i];
        set_req(i, p_addr[i], p_data[i]);
      end
      stall = ($urandom_range(0, 4) == 0);

      // Winner: the pending requester closest to the pointer, going upward with wrap.
      best = -1; bestd = N; nv = 0;
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          nv++;
          if (((i - m_ptr + N) % N) < bestd) begin
            bestd = (i - m_ptr + N) % N;
            best  = i;
          end
        end
      end
      if (stall) best = -1;
      exp_rdy = (best >= 0) ? N'(1 << best) : '0;
      #1;
      chk("rnd_ready", req_ready, exp_rdy);

      m_cont = !stall && (nv >= 2);
      m_en   = 0;
      if (!stall) begin
        for (int i = 0; i < N; i++) if (pend[i]) wait_c[i]++;
      end
      if (best >= 0) begin
        chk("rnd_starvation_ok", wait_c[best] <= N, 1);
        pend[best] = 0;
        m_ptr = (best + 1) % N;
`ifdef REGWR_ZERO_GUARD_EN
        if (p_addr[best] != 0) begin
`else
        begin
`endif
          m_en   = 1;
          m_addr = p_addr[best];
          m_data = p_data[best];
          m_src  = SW'(best);
        end
      end
      tick();
      chk("rnd_wr_en", wr_en, m_en);
      chk("rnd_wr_addr", wr_addr, m_addr);
      chk("rnd_wr_data", wr_data, m_data);
      chk("rnd_wr_src", wr_src, m_src);
      chk("rnd_contention", contention, m_cont);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
